// File: rtl/lrhls_mul_share_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier among NUM_REQ requesters.
// A credit counter bounds in-flight work to FIFO_DEPTH so the pipeline never needs to stall.
module lrhls_mul_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int A_W        = 18,
  parameter int B_W        = 13,
  parameter int P_W        = 31,
  parameter int TAG_W      = 4,
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_W-1:0]     req_a,
  input  logic [NUM_REQ*B_W-1:0]     req_b,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [P_W-1:0]             rsp_p,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant;
  logic             grant_found;
  logic             active;
  logic             can_accept;
  logic             accept;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] credit_used;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [A_W-1:0]          a_sel;
  logic [B_W-1:0]          b_sel;
  logic [TAG_W-1:0]        tag_sel;
  logic signed [P_W-1:0]   a_ext;
  logic signed [P_W-1:0]   b_ext;
  logic signed [P_W-1:0]   product;

  logic                    st_valid [PIPE_LAT];
  logic signed [P_W-1:0]   st_p     [PIPE_LAT];
  logic [ID_W-1:0]         st_id    [PIPE_LAT];
  logic [TAG_W-1:0]        st_tag   [PIPE_LAT];

  logic signed [P_W-1:0]   fifo_p   [FIFO_DEPTH];
  logic [ID_W-1:0]         fifo_id  [FIFO_DEPTH];
  logic [TAG_W-1:0]        fifo_tag [FIFO_DEPTH];

  // Search starts just after the last granted requester, wrapping at NUM_REQ-1.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant       = ID_W'(idx);
      end
    end
  end

  assign can_accept = (credit_used < CNT_W'(FIFO_DEPTH));
  assign accept     = active && can_accept && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  assign a_sel   = req_a[grant*A_W +: A_W];
  assign b_sel   = req_b[grant*B_W +: B_W];
  assign tag_sel = req_tag[grant*TAG_W +: TAG_W];
  assign a_ext   = {{(P_W-A_W){a_sel[A_W-1]}}, a_sel};
  assign b_ext   = {{(P_W-B_W){b_sel[B_W-1]}}, b_sel};
  assign product = a_ext * b_ext;

  assign push = st_valid[PIPE_LAT-1];
  assign pop  = rsp_valid && rsp_ready;

  // Control state: the active flag holds off grants until the first edge after reset release.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      active      <= 1'b0;
      ptr         <= ID_W'(NUM_REQ-1);
      credit_used <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int s = 0; s < PIPE_LAT; s++) st_valid[s] <= 1'b0;
    end else begin
      active      <= 1'b1;
      if (accept) ptr <= grant;
      credit_used <= credit_used + CNT_W'(accept) - CNT_W'(pop);
      st_valid[0] <= accept;
      for (int s = 1; s < PIPE_LAT; s++) st_valid[s] <= st_valid[s-1];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Datapath and FIFO storage carry no reset; validity is tracked by the control state above.
  always_ff @(posedge ap_clk) begin
    if (accept) begin
      st_p[0]   <= product;
      st_id[0]  <= grant;
      st_tag[0] <= tag_sel;
    end
    for (int s = 1; s < PIPE_LAT; s++) begin
      st_p[s]   <= st_p[s-1];
      st_id[s]  <= st_id[s-1];
      st_tag[s] <= st_tag[s-1];
    end
    if (push) begin
      fifo_p[wr_ptr]   <= st_p[PIPE_LAT-1];
      fifo_id[wr_ptr]  <= st_id[PIPE_LAT-1];
      fifo_tag[wr_ptr] <= st_tag[PIPE_LAT-1];
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_p     = rsp_valid ? fifo_p[rd_ptr]   : '0;
  assign rsp_id    = rsp_valid ? fifo_id[rd_ptr]  : '0;
  assign rsp_tag   = rsp_valid ? fifo_tag[rd_ptr] : '0;
  assign busy      = (credit_used != '0);

endmodule

// File: tb/tb_lrhls_mul_share_arbiter.sv
// Scoreboard bench for lrhls_mul_share_arbiter: a negedge monitor predicts grants, credits
// and result timing from the arbitration rules and compares every cycle.
module tb_lrhls_mul_share_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int A_W        = 18;
  localparam int B_W        = 13;
  localparam int P_W        = 31;
  localparam int TAG_W      = 4;
  localparam int PIPE_LAT   = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_W       = $clog2(NUM_REQ);

  logic                     ap_clk = 1'b0;
  logic                     ap_rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*A_W-1:0]   req_a;
  logic [NUM_REQ*B_W-1:0]   req_b;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [P_W-1:0]           rsp_p;
  logic [ID_W-1:0]          rsp_id;
  logic [TAG_W-1:0]         rsp_tag;
  logic                     busy;

  logic signed [A_W-1:0] a_arr   [NUM_REQ];
  logic signed [B_W-1:0] b_arr   [NUM_REQ];
  logic [TAG_W-1:0]      tag_arr [NUM_REQ];

  always #5 ap_clk = ~ap_clk;

  always_comb begin
    req_a   = '0;
    req_b   = '0;
    req_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*A_W +: A_W]       = a_arr[i];
      req_b[i*B_W +: B_W]       = b_arr[i];
      req_tag[i*TAG_W +: TAG_W] = tag_arr[i];
    end
  end

  lrhls_mul_share_arbiter #(
    .NUM_REQ(NUM_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W),
    .TAG_W(TAG_W), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  typedef struct {
    longint p;
    int     id;
    int     tag;
    int     avail;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_credit = 0;
  int m_ptr = NUM_REQ - 1;
  int m_g;
  int m_idx;
  logic m_exp_valid;
  logic m_pop;
  logic [NUM_REQ-1:0] m_exp_ready;

  int valid_pct = 0;
  int ready_pct = 100;
  logic [NUM_REQ-1:0] req_mask = '0;

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and monitor: result availability, grant order and credit limit come
  // straight from the rules (search from last grant + 1, accept while credits < depth).
  always @(negedge ap_clk) begin
    cyc++;
    if (!ap_rst_n) begin
      check_output("reset_req_ready", req_ready, 0);
      check_output("reset_rsp_valid", rsp_valid, 0);
      check_output("reset_busy", busy, 0);
      check_output("reset_rsp_p", rsp_p, 0);
      sb.delete();
      m_credit = 0;
      m_ptr    = NUM_REQ - 1;
    end else begin
      m_exp_valid = (sb.size() != 0) && (sb[0].avail <= cyc);
      check_output("rsp_valid", rsp_valid, m_exp_valid);
      if (m_exp_valid && rsp_valid) begin
        check_output("rsp_p", $signed(rsp_p), sb[0].p);
        check_output("rsp_id", longint'(rsp_id), sb[0].id);
        check_output("rsp_tag", longint'(rsp_tag), sb[0].tag);
      end
      m_pop = m_exp_valid && rsp_ready;
      check_output("busy", busy, (m_credit != 0) ? 1 : 0);

      m_g = -1;
      if (m_credit < FIFO_DEPTH) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          m_idx = (m_ptr + k) % NUM_REQ;
          if (m_g < 0 && req_valid[m_idx]) m_g = m_idx;
        end
      end
      m_exp_ready = '0;
      if (m_g >= 0) m_exp_ready[m_g] = 1'b1;
      check_output("req_ready", req_ready, m_exp_ready);

      if (m_g >= 0) begin
        sb.push_back('{p: longint'(a_arr[m_g]) * longint'(b_arr[m_g]),
                       id: m_g, tag: int'(tag_arr[m_g]), avail: cyc + PIPE_LAT + 1});
        m_ptr = m_g;
        m_credit++;
      end
      if (m_pop) begin
        void'(sb.pop_front());
        m_credit--;
      end
    end
  end

  task automatic new_op(input int i);
    case ($urandom_range(0, 7))
      0:       a_arr[i] = -18'sd131072;
      1:       a_arr[i] = 18'sd131071;
      2:       a_arr[i] = '0;
      default: a_arr[i] = A_W'($urandom);
    endcase
    case ($urandom_range(0, 7))
      0:       b_arr[i] = -13'sd4096;
      1:       b_arr[i] = 13'sd4095;
      2:       b_arr[i] = '0;
      default: b_arr[i] = B_W'($urandom);
    endcase
    tag_arr[i] = TAG_W'($urandom);
  endtask

  // Requesters only change after a handshake (or while idle), so valid never depends on ready.
  task automatic apply_stimulus(input int n, output int accepts);
    logic [NUM_REQ-1:0] hs;
    accepts = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge ap_clk);
      hs = req_valid & req_ready;
      accepts += $countones(hs);
      @(posedge ap_clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i] || !req_valid[i]) begin
          if (req_mask[i] && (int'($urandom_range(0, 99)) < valid_pct)) begin
            new_op(i);
            req_valid[i] = 1'b1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      rsp_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end
  endtask

  task automatic drain();
    int acc;
    req_mask  = '0;
    ready_pct = 100;
    for (int c = 0; c < 60 && (busy || req_valid != '0); c++) apply_stimulus(1, acc);
    check_output("drain_busy", busy, 0);
  endtask

  task automatic directed_op(input int id, input longint a, input longint b, input int tag,
                             input longint exp_p);
    logic got;
    int   lat;
    @(posedge ap_clk);
    #1;
    a_arr[id]     = A_W'(a);
    b_arr[id]     = B_W'(b);
    tag_arr[id]   = TAG_W'(tag);
    req_valid[id] = 1'b1;
    rsp_ready     = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge ap_clk);
      got = req_ready[id];
    end
    check_output("directed_grant", got, 1);
    @(posedge ap_clk);
    #1;
    req_valid[id] = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (rsp_valid) break;
      @(posedge ap_clk);
      #1;
      lat = c;
    end
    check_output("directed_latency", lat, PIPE_LAT);
    check_output("directed_p", $signed(rsp_p), exp_p);
    check_output("directed_id", longint'(rsp_id), id);
    check_output("directed_tag", longint'(rsp_tag), tag);
  endtask

  initial begin
    int acc;
    int acc2;
    int seen;
    logic [NUM_REQ-1:0] hs;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i]   = '0;
      b_arr[i]   = '0;
      tag_arr[i] = '0;
    end
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (3) @(posedge ap_clk);

    directed_op(1, -131072, 4095, 6, -536739840);
    directed_op(0, -131072, -4096, 3, 536870912);
    directed_op(2, 131071, 4095, 12, 536735745);
    directed_op(3, 0, -1234, 1, 0);
    drain();

    // All requesters held valid: grants must rotate 0,1,2,3,...
    req_mask = '1; valid_pct = 100; ready_pct = 100;
    apply_stimulus(40, acc);
    drain();

    // Backpressure: exactly FIFO_DEPTH accepts, then one pop frees exactly one more.
    req_mask = 1; valid_pct = 100; ready_pct = 0;
    apply_stimulus(12, acc);
    check_output("backpressure_accepts", acc, FIFO_DEPTH);
    ready_pct = 100;
    apply_stimulus(1, acc);
    ready_pct = 0;
    apply_stimulus(4, acc2);
    check_output("one_pop_one_accept", acc + acc2, 1);

    // Full FIFO drained while every requester keeps pushing.
    req_mask = '1; valid_pct = 100; ready_pct = 100;
    apply_stimulus(60, acc);
    valid_pct = 60; ready_pct = 70;
    apply_stimulus(400, acc);
    drain();

    // Reset with two operations in flight.
    rsp_ready = 1'b0;
    @(posedge ap_clk);
    #1;
    new_op(0); new_op(1);
    req_valid = 4'b0011;
    seen = 0;
    for (int c = 0; c < 10 && seen < 2; c++) begin
      @(negedge ap_clk);
      hs = req_valid & req_ready;
      @(posedge ap_clk);
      #1;
      req_valid = req_valid & ~hs;
      seen += $countones(hs);
    end
    check_output("inflight_ops", seen, 2);
    check_output("inflight_busy", busy, 1);
    #2 ap_rst_n = 1'b0;
    req_valid = '0;
    #1;
    check_output("async_req_ready", req_ready, 0);
    check_output("async_rsp_valid", rsp_valid, 0);
    check_output("async_busy", busy, 0);
    check_output("async_rsp_fields", {rsp_p, rsp_id, rsp_tag}, 0);
    repeat (2) @(negedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    req_mask = '1; valid_pct = 100; ready_pct = 100;
    apply_stimulus(20, acc);
    drain();

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
